// File: rtl/sec_monitor_mc.sv
`default_nettype none
// ============================================================================
//  sec_monitor_mc
//  Multi-core control-flow monitor: checks every retired-address transition
//  against a shared, run-time-writable graph; alarms, counts and drops.
//  Revision: 1.0
// ============================================================================
module sec_monitor_mc #(
  parameter  int          NUM_CORES  = 4,
  parameter  int          ADDR_W     = 32,
  parameter  int          IDX_W      = 11,
  parameter  int unsigned GRAPH_BASE = 0,
  localparam int          ENTRY_W    = 2*IDX_W+1,
  localparam int          SEL_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        core_sp_clk,
  input  logic                        reset,
  input  logic [NUM_CORES*ADDR_W-1:0] pc,
  input  logic [NUM_CORES-1:0]        pc_valid,
  input  logic [NUM_CORES-1:0]        pkt_done,
  input  logic [NUM_CORES-1:0]        enforce,
  input  logic                        gw_en,
  input  logic [IDX_W-1:0]            gw_addr,
  input  logic [ENTRY_W-1:0]          gw_data,
  output logic [NUM_CORES-1:0]        drop_packet,
  output logic [NUM_CORES-1:0]        alarm,
  input  logic [SEL_W-1:0]            cnt_sel,
  output logic [15:0]                 cnt_rd_data
);

  localparam int              HI_W  = ADDR_W - IDX_W - 2;
  localparam int              DEPTH = 1 << IDX_W;
  localparam logic [HI_W-1:0] BASE  = HI_W'(GRAPH_BASE);

  logic [15:0] cnt_all [NUM_CORES];

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    logic [ADDR_W-1:0]  core_pc;
    logic [IDX_W-1:0]   cur_idx;
    logic               accept;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] pred_entry;
    logic               prev_vld;
    logic [IDX_W-1:0]   prev_idx;
    logic [IDX_W-1:0]   seq_idx;
    logic [IDX_W-1:0]   succ_a;
    logic [IDX_W-1:0]   succ_b;
    logic               violation;
    logic               alarm_q;
    logic               drop_q;
    logic [15:0]        cnt_q;

    assign core_pc = pc[k*ADDR_W +: ADDR_W];
    assign cur_idx = core_pc[IDX_W+1:2];
    assign accept  = pc_valid[k] && (core_pc[1:0] == 2'b00) &&
                     (core_pc[ADDR_W-1:IDX_W+2] == BASE);

    // Private read port per core; non-blocking write keeps read-first order.
    always_ff @(posedge core_sp_clk) begin
      if (gw_en) begin
        mem[gw_addr] <= gw_data;
      end
      if (accept) begin
        pred_entry <= mem[cur_idx];
      end
    end

    assign seq_idx = prev_idx + IDX_W'(1);
    assign succ_a  = pred_entry[IDX_W:1];
    assign succ_b  = pred_entry[2*IDX_W:IDX_W+1];

    // A packet boundary makes the coincident address the first of a new packet.
    assign violation = accept && prev_vld && !pkt_done[k] && pred_entry[0] &&
                       (cur_idx != seq_idx) && (cur_idx != succ_a) &&
                       (cur_idx != succ_b);

    always_ff @(posedge core_sp_clk) begin
      if (reset) begin
        prev_vld <= 1'b0;
        prev_idx <= '0;
        alarm_q  <= 1'b0;
        drop_q   <= 1'b0;
        cnt_q    <= '0;
      end else begin
        alarm_q <= violation;
        if (accept) begin
          prev_vld <= 1'b1;
          prev_idx <= cur_idx;
        end else if (pkt_done[k]) begin
          prev_vld <= 1'b0;
        end
        if (violation && (cnt_q != 16'hFFFF)) begin
          cnt_q <= cnt_q + 16'd1;
        end
        if (pkt_done[k]) begin
          drop_q <= 1'b0;
        end else if (violation && enforce[k]) begin
          drop_q <= 1'b1;
        end
      end
    end

    assign alarm[k]       = alarm_q;
    assign drop_packet[k] = drop_q;
    assign cnt_all[k]     = cnt_q;
  end

  always_ff @(posedge core_sp_clk) begin
    if (reset) begin
      cnt_rd_data <= '0;
    end else begin
      cnt_rd_data <= cnt_all[cnt_sel];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sec_monitor_mc.sv
`default_nettype none
// Testbench for sec_monitor_mc: directed vectors, expected outputs queued per
// cycle by the stimulus and checked by an independent monitor process.
module tb_sec_monitor_mc;

  logic         clk;
  logic         reset;
  logic [127:0] pc;
  logic [3:0]   pc_valid;
  logic [3:0]   pkt_done;
  logic [3:0]   enforce;
  logic         gw_en;
  logic [10:0]  gw_addr;
  logic [22:0]  gw_data;
  logic [3:0]   drop_packet;
  logic [3:0]   alarm;
  logic [1:0]   cnt_sel;
  logic [15:0]  cnt_rd_data;

  sec_monitor_mc dut (
    .core_sp_clk (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .pkt_done    (pkt_done),
    .enforce     (enforce),
    .gw_en       (gw_en),
    .gw_addr     (gw_addr),
    .gw_data     (gw_data),
    .drop_packet (drop_packet),
    .alarm       (alarm),
    .cnt_sel     (cnt_sel),
    .cnt_rd_data (cnt_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [3:0]  a;
    logic [3:0]  d;
    bit          cc;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   step_id = 0;

  // Configuration applied by the next cycle task at its negedge.
  logic        rst_cfg = 1'b1;
  logic [3:0]  en_cfg  = 4'b0001;
  logic [1:0]  sel_cfg = 2'd0;
  logic        gwe_cfg = 1'b0;
  logic [10:0] ga_cfg  = '0;
  logic [22:0] gd_cfg  = '0;

  function automatic logic [127:0] pk(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [22:0] ent(input logic [10:0] b, a, input logic v);
    return {b, a, v};
  endfunction

  task automatic cyc(input logic [127:0] pcv, input logic [3:0] v, input logic [3:0] d,
                     input bit chk, input logic [3:0] ea, input logic [3:0] ed,
                     input bit cc, input logic [15:0] ec);
    exp_t e;
    @(negedge clk);
    reset    = rst_cfg;
    enforce  = en_cfg;
    cnt_sel  = sel_cfg;
    gw_en    = gwe_cfg;
    gw_addr  = ga_cfg;
    gw_data  = gd_cfg;
    gwe_cfg  = 1'b0;
    pc       = pcv;
    pc_valid = v;
    pkt_done = d;
    if (chk) begin
      step_id++;
      e.id = step_id; e.a = ea; e.d = ed; e.cc = cc; e.c = ec;
      sb.push_back(e);
    end
  endtask

  task automatic c0(input logic [31:0] addr, input logic done, input logic [3:0] ea,
                    input logic [3:0] ed);
    cyc(pk(addr, 0, 0, 0), 4'b0001, {3'b000, done}, 1'b1, ea, ed, 1'b0, 16'd0);
  endtask

  task automatic idle(input logic [3:0] d, input logic [3:0] ea, input logic [3:0] ed,
                      input logic [15:0] ec);
    cyc('0, 4'b0000, d, 1'b1, ea, ed, 1'b1, ec);
  endtask

  task automatic wr(input logic [10:0] idx, input logic [22:0] data);
    ga_cfg = idx; gd_cfg = data; gwe_cfg = 1'b1;
    cyc('0, 4'b0000, 4'b0000, 1'b0, '0, '0, 1'b0, 16'd0);
  endtask

  // Monitor: compares DUT outputs one step after each queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (alarm !== e.a) begin
          fails++;
          $display("FAIL alarm step %0d: got %b expected %b", e.id, alarm, e.a);
        end
        tests++;
        if (drop_packet !== e.d) begin
          fails++;
          $display("FAIL drop_packet step %0d: got %b expected %b", e.id, drop_packet, e.d);
        end
        if (e.cc) begin
          tests++;
          if (cnt_rd_data !== e.c) begin
            fails++;
            $display("FAIL cnt_rd_data step %0d: got %h expected %h", e.id, cnt_rd_data, e.c);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc = '0; pc_valid = '0; pkt_done = '0; enforce = '0;
    gw_en = 1'b0; gw_addr = '0; gw_data = '0; cnt_sel = '0;

    // Reset state
    idle(4'b0000, 4'b0000, 4'b0000, 16'd0);
    idle(4'b0000, 4'b0000, 4'b0000, 16'd0);
    rst_cfg = 1'b0;

    for (int i = 0; i < 2048; i++) wr(11'(i), '0);
    wr(11'h010, ent(11'h040, 11'h020, 1'b1));
    wr(11'h040, ent(11'h050, 11'h060, 1'b1));
    wr(11'h7FF, ent(11'h001, 11'h001, 1'b1));

    // Legal jumps, core 0 enforce
    en_cfg = 4'b0001; sel_cfg = 2'd0;
    c0(32'h40,  1'b0, 4'b0000, 4'b0000);
    c0(32'h80,  1'b0, 4'b0000, 4'b0000);
    c0(32'h40,  1'b0, 4'b0000, 4'b0000);
    c0(32'h44,  1'b0, 4'b0000, 4'b0000);
    c0(32'h40,  1'b0, 4'b0000, 4'b0000);
    c0(32'h100, 1'b0, 4'b0000, 4'b0000);
    c0(32'h104, 1'b0, 4'b0000, 4'b0000);
    c0(32'h40,  1'b0, 4'b0000, 4'b0000);
    // Illegal jump 0x10 -> 0x30
    c0(32'hC0,  1'b0, 4'b0001, 4'b0001);
    idle(4'b0000, 4'b0000, 4'b0001, 16'd1);
    c0(32'h40,  1'b0, 4'b0000, 4'b0001);
    // Repeated identical index is a violation; drop stays set
    c0(32'h40,  1'b0, 4'b0001, 4'b0001);
    idle(4'b0000, 4'b0000, 4'b0001, 16'd2);
    // Packet boundary
    c0(32'h100, 1'b1, 4'b0000, 4'b0000);
    c0(32'h104, 1'b0, 4'b0000, 4'b0000);
    c0(32'h100, 1'b1, 4'b0000, 4'b0000);
    c0(32'h300, 1'b0, 4'b0001, 4'b0001);
    c0(32'h40,  1'b0, 4'b0000, 4'b0001);
    c0(32'hC0,  1'b1, 4'b0000, 4'b0000);
    idle(4'b0000, 4'b0000, 4'b0000, 16'd3);

    // Monitor-only mode
    en_cfg = 4'b0000;
    c0(32'h40,  1'b0, 4'b0000, 4'b0000);
    c0(32'hC0,  1'b0, 4'b0001, 4'b0000);
    idle(4'b0000, 4'b0000, 4'b0000, 16'd4);

    // Wrap and unmonitored entries
    en_cfg = 4'b0001;
    c0(32'h1FFC, 1'b0, 4'b0000, 4'b0000);
    c0(32'h0000, 1'b0, 4'b0000, 4'b0000);
    c0(32'h1FFC, 1'b0, 4'b0000, 4'b0000);
    c0(32'h0008, 1'b0, 4'b0001, 4'b0001);
    idle(4'b0001, 4'b0000, 4'b0000, 16'd5);
    c0(32'h80,  1'b0, 4'b0000, 4'b0000);
    c0(32'h800, 1'b0, 4'b0000, 4'b0000);

    // Window and alignment filter leave the predecessor untouched
    c0(32'h40,      1'b0, 4'b0000, 4'b0000);
    c0(32'h1_0000,  1'b0, 4'b0000, 4'b0000);
    c0(32'h42,      1'b0, 4'b0000, 4'b0000);
    cyc(pk(32'h1000, 0, 0, 0), 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'd0);
    c0(32'hC0,      1'b0, 4'b0001, 4'b0001);
    idle(4'b0001, 4'b0000, 4'b0000, 16'd6);

    // Multi-core concurrency: violations only on cores 1 and 3
    en_cfg = 4'b1111; sel_cfg = 2'd1;
    cyc(pk(32'h40, 32'h40, 32'h40, 32'h40), 4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'd0);
    cyc(pk(32'h44, 32'hC0, 32'h80, 32'h40), 4'b1111, 4'b0000, 1'b1, 4'b1010, 4'b1010, 1'b0, 16'd0);
    cyc(pk(32'h48, 32'h40, 32'h84, 32'hC0), 4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b1010, 1'b1, 16'd1);
    sel_cfg = 2'd3;
    idle(4'b0000, 4'b0000, 4'b1010, 16'd2);

    // Write/read collision: check uses the entry as it was before the write
    ga_cfg = 11'h050; gd_cfg = ent(11'h000, 11'h000, 1'b1); gwe_cfg = 1'b1;
    c0(32'h140, 1'b1, 4'b0000, 4'b1010);
    c0(32'h300, 1'b0, 4'b0000, 4'b1010);
    c0(32'h140, 1'b0, 4'b0000, 4'b1010);
    c0(32'h300, 1'b0, 4'b0001, 4'b1011);

    // Reset mid-stream; graph retained
    rst_cfg = 1'b1; sel_cfg = 2'd1;
    idle(4'b0000, 4'b0000, 4'b0000, 16'd0);
    rst_cfg = 1'b0;
    idle(4'b0000, 4'b0000, 4'b0000, 16'd0);
    c0(32'h140, 1'b0, 4'b0000, 4'b0000);
    c0(32'h300, 1'b0, 4'b0001, 4'b0001);

    // Counter saturation on core 1
    for (int i = 0; i < 65537; i++) begin
      cyc(pk(0, 32'h40, 0, 0), 4'b0010, 4'b0000, 1'b0, '0, '0, 1'b0, 16'd0);
    end
    cyc(pk(0, 32'h40, 0, 0), 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0011, 1'b0, 16'd0);
    idle(4'b0000, 4'b0000, 4'b0011, 16'hFFFF);

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
